// File: rtl/adc_cmd_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_cmd_responder_if
// Description : Avalon-ST style command/response channel between an ADC
//               command source (master) and the ADC responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
interface adc_cmd_responder_if;
    logic        command_valid;
    logic [4:0]  command_channel;
    logic        command_startofpacket;
    logic        command_endofpacket;
    logic        command_ready;
    logic        response_valid;
    logic [4:0]  response_channel;
    logic [11:0] response_data;
    logic        response_startofpacket;
    logic        response_endofpacket;
    logic        busy;

    modport slave (
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        output command_ready, response_valid, response_channel, response_data,
        output response_startofpacket, response_endofpacket, busy
    );

    modport master (
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  command_ready, response_valid, response_channel, response_data,
        input  response_startofpacket, response_endofpacket, busy
    );
endinterface
`default_nettype wire

// File: rtl/adc_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : adc_cmd_responder
// Description : Cycle-accurate stand-in for the modular ADC command/response
//               interface. Accepts one command, waits CONV_CYCLES, returns a
//               single-cycle response with synthetic sample data.
//               Optional macro ADC_NOISE_EN adds LFSR noise to temperature
//               samples (saturating at 12'hFFF).
// Revision    : 1.0  initial release
// ============================================================================
module adc_cmd_responder #(
    parameter int unsigned CONV_CYCLES  = 50,
    parameter int unsigned TEMP_CHANNEL = 17,
    parameter int unsigned TEMP_BASE    = 3431,
    parameter int unsigned MAX_CHANNEL  = 17
) (
    input  logic              clock,
    input  logic              reset,
    adc_cmd_responder_if.slave bus
);

    localparam logic [9:0]  c_COUNT_LOAD = 10'(CONV_CYCLES - 1);
    localparam logic [4:0]  c_TEMP_CH    = 5'(TEMP_CHANNEL);
    localparam logic [4:0]  c_MAX_CH     = 5'(MAX_CHANNEL);
    localparam logic [11:0] c_TEMP_BASE  = 12'(TEMP_BASE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t      r_state;
    logic [9:0]  r_count;
    logic [4:0]  r_channel;
    logic [6:0]  r_conv_count;
    logic [5:0]  r_offset;
    logic        r_dir_down;
    logic        r_command_ready;
    logic        r_response_valid;
    logic        r_response_sop;
    logic        r_response_eop;
    logic [4:0]  r_response_channel;
    logic [11:0] r_response_data;
    logic        r_busy;

    logic        w_finish;
    logic        w_is_temp;
    logic        w_is_invalid;
    logic        w_temp_done;
    logic [11:0] w_temp_sum;
    logic [11:0] w_temp_data;
    logic [11:0] w_data;
    logic        w_unused_sop_eop;

    // Packet delimiters on the command side carry no information here.
    assign w_unused_sop_eop = bus.command_startofpacket ^ bus.command_endofpacket;

    assign w_finish     = (r_state == S_CONVERT) && (r_count == 10'd1);
    assign w_is_temp    = (r_channel == c_TEMP_CH);
    assign w_is_invalid = (r_channel > c_MAX_CH);
    assign w_temp_done  = w_finish && w_is_temp;
    assign w_temp_sum   = c_TEMP_BASE + {6'd0, r_offset};

`ifdef ADC_NOISE_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;
    logic [12:0] w_noisy;

    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_noisy     = {1'b0, w_temp_sum} + {11'd0, r_lfsr[1:0]};
    assign w_temp_data = w_noisy[12] ? 12'hFFF : w_noisy[11:0];

    // Noise source steps once per temperature response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (w_temp_done) begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end
`else
    assign w_temp_data = w_temp_sum;
`endif

    // Sample value for the conversion that is completing now.
    always_comb begin
        w_data = 12'h000;
        if (w_is_temp) begin
            w_data = w_temp_data;
        end else if (!w_is_invalid) begin
            w_data = {r_channel, r_conv_count};
        end
    end

    // Triangle ramp 0..63..0 advancing after each temperature response.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_offset   <= 6'd0;
            r_dir_down <= 1'b0;
        end else if (w_temp_done) begin
            if (!r_dir_down) begin
                if (r_offset == 6'd63) begin
                    r_offset   <= 6'd62;
                    r_dir_down <= 1'b1;
                end else begin
                    r_offset <= r_offset + 6'd1;
                end
            end else begin
                if (r_offset == 6'd0) begin
                    r_offset   <= 6'd1;
                    r_dir_down <= 1'b0;
                end else begin
                    r_offset <= r_offset - 6'd1;
                end
            end
        end
    end

    // Command FSM with registered handshake and response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= S_IDLE;
            r_count            <= 10'd0;
            r_channel          <= 5'd0;
            r_conv_count       <= 7'd0;
            r_command_ready    <= 1'b0;
            r_response_valid   <= 1'b0;
            r_response_sop     <= 1'b0;
            r_response_eop     <= 1'b0;
            r_response_channel <= 5'd0;
            r_response_data    <= 12'd0;
            r_busy             <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_command_ready <= 1'b1;
                    if (bus.command_valid && r_command_ready) begin
                        r_channel       <= bus.command_channel;
                        r_count         <= c_COUNT_LOAD;
                        r_command_ready <= 1'b0;
                        r_busy          <= 1'b1;
                        r_state         <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    if (r_count == 10'd1) begin
                        r_state            <= S_RESPOND;
                        r_busy             <= 1'b0;
                        r_response_valid   <= 1'b1;
                        r_response_sop     <= 1'b1;
                        r_response_eop     <= 1'b1;
                        r_response_channel <= r_channel;
                        r_response_data    <= w_data;
                        r_conv_count       <= r_conv_count + 7'd1;
                    end else begin
                        r_count <= r_count - 10'd1;
                    end
                end
                S_RESPOND: begin
                    r_response_valid <= 1'b0;
                    r_response_sop   <= 1'b0;
                    r_response_eop   <= 1'b0;
                    r_command_ready  <= 1'b1;
                    r_state          <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.command_ready          = r_command_ready;
    assign bus.response_valid         = r_response_valid;
    assign bus.response_startofpacket = r_response_sop;
    assign bus.response_endofpacket   = r_response_eop;
    assign bus.response_channel       = r_response_channel;
    assign bus.response_data          = r_response_data;
    assign bus.busy                   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_adc_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_cmd_responder
// Description : Self-checking bench for adc_cmd_responder (default build and
//               ADC_NOISE_EN build). Main instance uses default parameters,
//               second instance uses CONV_CYCLES=2, TEMP_BASE=4094.
// Revision    : 1.0  initial release
// ============================================================================
module tb_adc_cmd_responder;

    localparam int N = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    adc_cmd_responder_if bus ();
    adc_cmd_responder_if bus2 ();

    adc_cmd_responder dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    adc_cmd_responder #(
        .CONV_CYCLES (2),
        .TEMP_BASE   (4094)
    ) dut2 (
        .clock (clk),
        .reset (rst),
        .bus   (bus2)
    );

    typedef struct {
        logic [4:0]  ch;
        logic [11:0] data;
        int          due;
    } sb_t;

    typedef struct {
        logic [4:0]  ch;
        logic [11:0] exp_data;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[9];

    int          last_resp    = -1;
    bit          gap_check    = 1'b0;
    bit          hold_pending = 1'b0;
    logic [4:0]  held_ch;
    logic [11:0] held_data;
    logic [15:0] m_lfsr       = 16'hACE1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Noise contribution of the next temperature sample (zero without the macro).
    function automatic logic [1:0] next_noise();
        logic [1:0] r;
        r = 2'b00;
`ifdef ADC_NOISE_EN
        r = m_lfsr[1:0];
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
        return r;
    endfunction

    function automatic int tri_of(input int i);
        int k;
        k = i % 126;
        return (k <= 63) ? k : 126 - k;
    endfunction

    task automatic push_exp(input logic [4:0] ch, input logic [11:0] data);
        logic [11:0] d;
        d = data;
        if (ch == 5'd17) d = d + {10'd0, next_noise()};
        sb.push_back('{ch, d, cyc + N});
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.command_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) check("ready_timeout", bus.command_ready, 1);
    endtask

    task automatic send(input logic [4:0] ch, input logic [11:0] data, output int acc);
        wait_ready();
        bus.command_valid   = 1'b1;
        bus.command_channel = ch;
        acc = cyc;
        push_exp(ch, data);
        @(negedge clk);
        bus.command_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    // Response monitor / scoreboard for the main instance.
    always @(negedge clk) begin
        sb_t e;
        if (!rst) begin
            if (bus.response_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_response", bus.response_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("resp_channel", bus.response_channel, e.ch);
                    check("resp_data", bus.response_data, e.data);
                    check("resp_sop", bus.response_startofpacket, 1);
                    check("resp_eop", bus.response_endofpacket, 1);
                    check("resp_cycle", cyc, e.due);
                end
                if (gap_check && last_resp >= 0) check("resp_spacing", cyc - last_resp, N + 1);
                last_resp    = cyc;
                hold_pending = 1'b1;
                held_ch      = bus.response_channel;
                held_data    = bus.response_data;
            end else if (hold_pending) begin
                hold_pending = 1'b0;
                check("hold_channel", bus.response_channel, held_ch);
                check("hold_data", bus.response_data, held_data);
                check("strobe_sop_low", bus.response_startofpacket, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        logic [11:0] exp2;

        bus.command_valid          = 1'b0;
        bus.command_channel        = 5'd0;
        bus.command_startofpacket  = 1'b0;
        bus.command_endofpacket    = 1'b0;
        bus2.command_valid         = 1'b0;
        bus2.command_channel       = 5'd0;
        bus2.command_startofpacket = 1'b0;
        bus2.command_endofpacket   = 1'b0;

        vecs[0] = '{5'd17, 12'd3432};
        vecs[1] = '{5'd17, 12'd3433};
        vecs[2] = '{5'd5,  12'h283};
        vecs[3] = '{5'd20, 12'h000};
        vecs[4] = '{5'd3,  12'h185};
        vecs[5] = '{5'd17, 12'd3434};
        vecs[6] = '{5'd0,  12'h007};
        vecs[7] = '{5'd31, 12'h000};
        vecs[8] = '{5'd16, 12'h809};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", bus.command_ready, 0);
        check("rst_valid", bus.response_valid, 0);
        check("rst_sop", bus.response_startofpacket, 0);
        check("rst_eop", bus.response_endofpacket, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_channel", bus.response_channel, 0);
        check("rst_data", bus.response_data, 0);
        rst = 1'b0;
        check("ready_before_edge", bus.command_ready, 0);
        @(negedge clk);
        check("ready_after_edge", bus.command_ready, 1);

        // First temperature command, exact latency
        repeat (8) @(negedge clk);
        send(5'd17, 12'd3431, acc);
        check("busy_convert", bus.busy, 1);
        check("ready_convert", bus.command_ready, 0);
        while (cyc < acc + N) @(negedge clk);
        check("ready_respond", bus.command_ready, 0);
        @(negedge clk);
        check("ready_back", bus.command_ready, 1);

        // Table of channels; a stray command with another channel mid-conversion
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].ch, vecs[i].exp_data, acc);
            repeat (10) @(negedge clk);
            bus.command_channel = ~vecs[i].ch;
            bus.command_valid   = 1'b1;
            repeat (3) @(negedge clk);
            bus.command_valid   = 1'b0;
        end
        drain();

        // Reset in the middle of a conversion discards it
        send(5'd17, 12'd0, acc);
        repeat (19) @(negedge clk);
        check("busy_before_reset", bus.busy, 1);
        rst = 1'b1;
        sb.delete();
        m_lfsr = 16'hACE1;
        @(negedge clk);
        check("midrst_ready", bus.command_ready, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_data", bus.response_data, 0);
        @(negedge clk);
        rst = 1'b0;
        hold_pending = 1'b0;
        repeat (60) @(negedge clk);
        check("post_reset_ready", bus.command_ready, 1);
        check("post_reset_valid", bus.response_valid, 0);

        // Back-to-back temperature commands with valid held high
        gap_check = 1'b1;
        last_resp = -1;
        bus.command_channel = 5'd17;
        bus.command_valid   = 1'b1;
        for (int i = 0; i < 70; i++) begin
            wait_ready();
            push_exp(5'd17, 12'(3431 + tri_of(i)));
            @(negedge clk);
        end
        bus.command_valid = 1'b0;
        drain();
        gap_check = 1'b0;

        // Short conversion instance: latency 2, command during CONVERT ignored
`ifdef ADC_NOISE_EN
        exp2 = 12'd4095;
`else
        exp2 = 12'd4094;
`endif
        n = 0;
        while (bus2.command_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("n2_ready", bus2.command_ready, 1);
        bus2.command_channel = 5'd17;
        bus2.command_valid   = 1'b1;
        @(negedge clk);
        check("n2_no_early_valid", bus2.response_valid, 0);
        check("n2_busy", bus2.busy, 1);
        @(negedge clk);
        check("n2_valid", bus2.response_valid, 1);
        check("n2_channel", bus2.response_channel, 17);
        check("n2_data_first", bus2.response_data, exp2);
        bus2.command_valid = 1'b0;
        @(negedge clk);
        check("n2_valid_drop", bus2.response_valid, 0);
        check("n2_ready_back", bus2.command_ready, 1);
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus2.response_valid === 1'b1) n++;
        end
        check("n2_extra_responses", n, 0);

        // Second temperature sample sits at the 12-bit ceiling
        bus2.command_valid = 1'b1;
        @(negedge clk);
        bus2.command_valid = 1'b0;
        @(negedge clk);
        check("n2_valid_second", bus2.response_valid, 1);
        check("n2_data_ceiling", bus2.response_data, 12'hFFF);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
